fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with fetch/decode pipeline register and one-entry skid buffer.
// Optional macro FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module fetch_stage #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_PC  = 32'h0000_0000,
  parameter logic [WIDTH-1:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             stall_d_i,
  input  logic             flush_d_i,
  input  logic             pc_src_e_i,
  input  logic [WIDTH-1:0] pc_target_e_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] instr_d_o,
  output logic [WIDTH-1:0] pc_d_o,
  output logic [WIDTH-1:0] pc_plus_4_d_o,
  output logic             valid_d_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      redirect_cnt_o
);

  typedef enum logic {FETCH, DISCARD} state_t;
  typedef enum logic [1:0] {D_HOLD, D_BUBBLE, D_MEM, D_BUF} dsel_t;

  localparam logic [WIDTH-1:0] FOUR     = WIDTH'(4);
  localparam logic [WIDTH-1:0] PC_RESET = {RESET_PC[WIDTH-1:2], 2'b00};

  state_t           state, state_nxt;
  dsel_t            dsel;
  logic [WIDTH-1:0] pc_f, pc_f_nxt, redir_pc, redir_pc_nxt;
  logic [WIDTH-1:0] buf_instr, buf_pc;
  logic             buf_valid, buf_load, buf_clr;
  logic             ack, fetched;
  logic [WIDTH-1:0] target;
  logic             unused_tgt_lsb;

  assign target         = {pc_target_e_i[WIDTH-1:2], 2'b00};
  assign unused_tgt_lsb = ^pc_target_e_i[1:0];
  assign imem_req_o     = rst_n_i && !buf_valid;
  assign imem_addr_o    = pc_f;
  assign ack            = imem_req_o && imem_ack_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= FETCH;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pc_f_nxt     = pc_f;
    redir_pc_nxt = redir_pc;
    dsel         = D_HOLD;
    buf_load     = 1'b0;
    buf_clr      = 1'b0;
    fetched      = 1'b0;
    if (pc_src_e_i) begin
      dsel    = D_BUBBLE;
      buf_clr = 1'b1;
      if (state == DISCARD) begin
        if (ack) begin
          pc_f_nxt  = target;
          state_nxt = FETCH;
        end else begin
          redir_pc_nxt = target;
        end
      end else if (imem_req_o && !ack) begin
        // keep the old address on the bus until memory answers, then drop it
        state_nxt    = DISCARD;
        redir_pc_nxt = target;
      end else begin
        pc_f_nxt = target;
      end
    end else begin
      if (state == DISCARD) begin
        if (ack) begin
          pc_f_nxt  = redir_pc;
          state_nxt = FETCH;
        end
      end else if (ack) begin
        pc_f_nxt = pc_f + FOUR;
        fetched  = 1'b1;
      end
      if (flush_d_i) begin
        dsel     = D_BUBBLE;
        buf_load = fetched;
      end else if (stall_d_i) begin
        buf_load = fetched;
      end else if (buf_valid) begin
        dsel    = D_BUF;
        buf_clr = 1'b1;
      end else if (fetched) begin
        dsel = D_MEM;
      end else begin
        dsel = D_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_f          <= PC_RESET;
      redir_pc      <= '0;
      buf_valid     <= 1'b0;
      buf_instr     <= '0;
      buf_pc        <= '0;
      instr_d_o     <= NOP_INSTR;
      pc_d_o        <= '0;
      pc_plus_4_d_o <= '0;
      valid_d_o     <= 1'b0;
    end else begin
      pc_f     <= pc_f_nxt;
      redir_pc <= redir_pc_nxt;
      if (buf_clr) begin
        buf_valid <= 1'b0;
      end else if (buf_load) begin
        buf_valid <= 1'b1;
        buf_instr <= imem_rdata_i;
        buf_pc    <= pc_f;
      end
      unique case (dsel)
        D_BUBBLE: begin
          valid_d_o <= 1'b0;
          instr_d_o <= NOP_INSTR;
        end
        D_MEM: begin
          valid_d_o     <= 1'b1;
          instr_d_o     <= imem_rdata_i;
          pc_d_o        <= pc_f;
          pc_plus_4_d_o <= pc_f + FOUR;
        end
        D_BUF: begin
          valid_d_o     <= 1'b1;
          instr_d_o     <= buf_instr;
          pc_d_o        <= buf_pc;
          pc_plus_4_d_o <= buf_pc + FOUR;
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, redirect_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall_d_i && !pc_src_e_i && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (pc_src_e_i && redirect_cnt != 32'hFFFF_FFFF)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

  assign stall_cnt_o    = stall_cnt;
  assign redirect_cnt_o = redirect_cnt;
`else
  assign stall_cnt_o    = '0;
  assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, hand sequences, and random traffic vs. a queue-based model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, pc_src, ack;
  logic [31:0] tgt, addr, rdata, instr, pc_d, pc4, scnt, rcnt;
  logic        req, valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a + 32'h1000_0000;
  endfunction

  assign rdata = mem_fn(addr);

  fetch_stage #(.WIDTH(32), .RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_d_i(stall), .flush_d_i(flush),
    .pc_src_e_i(pc_src), .pc_target_e_i(tgt),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_rdata_i(rdata),
    .instr_d_o(instr), .pc_d_o(pc_d), .pc_plus_4_d_o(pc4), .valid_d_o(valid),
    .stall_cnt_o(scnt), .redirect_cnt_o(rcnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic p,
                       input logic [31:0] t, input logic a);
    rst_n = r; stall = s; flush = f; pc_src = p; tgt = t; ack = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: fetch pointer, pending-drop flag, skid queue of fetched PCs.
  logic        m_rst;
  logic [31:0] m_pc, m_redir, m_pc_d;
  logic        m_drop, m_v;
  logic [31:0] bufq[$];
  logic [31:0] m_scnt, m_rcnt;

  task automatic model_step(input logic r, input logic s, input logic f, input logic p,
                            input logic [31:0] t, input logic a);
    logic        mreq, got;
    logic [31:0] fpc, al;
    m_rst = r;
    if (!r) begin
      m_pc = RPC; m_drop = 1'b0; bufq.delete(); m_v = 1'b0; m_pc_d = 32'h0;
      m_scnt = 32'h0; m_rcnt = 32'h0;
      return;
    end
    mreq = (bufq.size() == 0);
    got  = mreq && a;
    fpc  = m_pc;
    if (s && !p && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
    if (p && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 32'd1;
    if (p) begin
      al = {t[31:2], 2'b00};
      m_v = 1'b0;
      bufq.delete();
      if (m_drop) begin
        if (got) begin m_pc = al; m_drop = 1'b0; end
        else m_redir = al;
      end else if (mreq && !got) begin
        m_drop = 1'b1; m_redir = al;
      end else begin
        m_pc = al;
      end
      return;
    end
    if (got) begin
      if (m_drop) begin m_pc = m_redir; m_drop = 1'b0; got = 1'b0; end
      else m_pc = m_pc + 32'd4;
    end
    if (f) begin
      m_v = 1'b0;
      if (got) bufq.push_back(fpc);
    end else if (s) begin
      if (got) bufq.push_back(fpc);
    end else if (bufq.size() > 0) begin
      m_v = 1'b1; m_pc_d = bufq.pop_front();
    end else if (got) begin
      m_v = 1'b1; m_pc_d = fpc;
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic model_compare(input int cyc);
    string tag;
    tag = $sformatf("rnd%0d", cyc);
    chk1({tag, "_valid"}, valid, m_v);
    chk32({tag, "_instr"}, instr, m_v ? mem_fn(m_pc_d) : NOP);
    if (m_v || !m_rst) begin
      chk32({tag, "_pc"}, pc_d, m_v ? m_pc_d : 32'h0);
      chk32({tag, "_pc4"}, pc4, m_v ? m_pc_d + 32'd4 : 32'h0);
    end
    chk1({tag, "_req"}, req, m_rst && bufq.size() == 0);
    chk32({tag, "_addr"}, addr, m_pc);
`ifdef FETCH_PERF_CNT_EN
    chk32({tag, "_scnt"}, scnt, m_scnt);
    chk32({tag, "_rcnt"}, rcnt, m_rcnt);
`else
    chk32({tag, "_scnt"}, scnt, 32'h0);
    chk32({tag, "_rcnt"}, rcnt, 32'h0);
`endif
  endtask

  typedef struct {
    logic rst, stall, flush, redir; logic [31:0] tgt; logic ack;
    logic v; logic [31:0] pc, pp4; logic req; logic [31:0] addr;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // rst stall flush redir tgt ack | valid pc pc+4 req addr (observed after the edge)
    tbl[0]  = '{H,L,L,L,32'h0,H,           H,32'h0,32'h4,H,32'h4};
    tbl[1]  = '{H,L,L,L,32'h0,H,           H,32'h4,32'h8,H,32'h8};
    tbl[2]  = '{H,L,L,L,32'h0,H,           H,32'h8,32'hC,H,32'hC};
    tbl[3]  = '{H,H,L,L,32'h0,H,           H,32'h8,32'hC,L,32'h10};
    tbl[4]  = '{H,H,L,L,32'h0,H,           H,32'h8,32'hC,L,32'h10};
    tbl[5]  = '{H,H,L,L,32'h0,H,           H,32'h8,32'hC,L,32'h10};
    tbl[6]  = '{H,L,L,L,32'h0,H,           H,32'hC,32'h10,H,32'h10};
    tbl[7]  = '{H,L,L,L,32'h0,H,           H,32'h10,32'h14,H,32'h14};
    tbl[8]  = '{H,L,L,H,32'h102,H,         L,32'h0,32'h0,H,32'h100};
    tbl[9]  = '{H,L,L,L,32'h0,H,           H,32'h100,32'h104,H,32'h104};
    tbl[10] = '{H,L,L,H,32'h40,H,          L,32'h0,32'h0,H,32'h40};
    tbl[11] = '{H,L,L,H,32'h200,L,         L,32'h0,32'h0,H,32'h40};
    tbl[12] = '{H,L,L,L,32'h0,L,           L,32'h0,32'h0,H,32'h40};
    tbl[13] = '{H,L,L,L,32'h0,H,           L,32'h0,32'h0,H,32'h200};
    tbl[14] = '{H,L,L,L,32'h0,H,           H,32'h200,32'h204,H,32'h204};
    tbl[15] = '{H,L,L,H,32'hFFFF_FFFF,H,   L,32'h0,32'h0,H,32'hFFFF_FFFC};
    tbl[16] = '{H,L,L,L,32'h0,H,           H,32'hFFFF_FFFC,32'h0,H,32'h0};
    tbl[17] = '{H,L,H,L,32'h0,H,           L,32'h0,32'h0,L,32'h4};
    tbl[18] = '{H,L,L,L,32'h0,H,           H,32'h0,32'h4,H,32'h4};
    tbl[19] = '{H,L,L,L,32'h0,H,           H,32'h4,32'h8,H,32'h8};
    tbl[20] = '{H,L,L,H,32'h300,L,         L,32'h0,32'h0,H,32'h8};
    tbl[21] = '{L,L,L,L,32'h0,L,           L,32'h0,32'h0,L,RPC};
    tbl[22] = '{H,L,L,L,32'h0,H,           H,32'h0,32'h4,H,32'h4};

    // reset state
    drive(L, L, L, L, 32'h0, L);
    repeat (3) tick();
    chk1("rst_valid", valid, 1'b0);
    chk32("rst_instr", instr, NOP);
    chk32("rst_pc", pc_d, 32'h0);
    chk32("rst_pc4", pc4, 32'h0);
    chk1("rst_req", req, 1'b0);
    chk32("rst_scnt", scnt, 32'h0);
    chk32("rst_rcnt", rcnt, 32'h0);
    rst_n = H;
    #1;
    chk1("rel_req", req, 1'b1);
    chk32("rel_addr", addr, RPC);

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].redir, tbl[i].tgt, tbl[i].ack);
      tick();
      chk1($sformatf("row%0d_valid", i), valid, tbl[i].v);
      chk32($sformatf("row%0d_instr", i), instr, tbl[i].v ? mem_fn(tbl[i].pc) : NOP);
      if (tbl[i].v || !tbl[i].rst) begin
        chk32($sformatf("row%0d_pc", i), pc_d, tbl[i].pc);
        chk32($sformatf("row%0d_pc4", i), pc4, tbl[i].pp4);
      end
      chk1($sformatf("row%0d_req", i), req, tbl[i].req);
      chk32($sformatf("row%0d_addr", i), addr, tbl[i].addr);
    end

    // counters: reset in row 21, then 5 stall-only and 2 redirect-only cycles
    repeat (5) begin drive(H, H, L, L, 32'h0, H); tick(); end
    repeat (2) begin drive(H, L, L, H, 32'h500, H); tick(); end
`ifdef FETCH_PERF_CNT_EN
    chk32("cnt_stall", scnt, 32'd5);
    chk32("cnt_redir", rcnt, 32'd2);
`else
    chk32("cnt_stall", scnt, 32'd0);
    chk32("cnt_redir", rcnt, 32'd0);
`endif
    drive(H, H, L, H, 32'h600, H);
    tick();
`ifdef FETCH_PERF_CNT_EN
    chk32("cnt_stall_redir", scnt, 32'd5);
    chk32("cnt_redir_stall", rcnt, 32'd3);
`else
    chk32("cnt_stall_redir", scnt, 32'd0);
    chk32("cnt_redir_stall", rcnt, 32'd0);
`endif

    // random traffic against the model
    drive(L, L, L, L, 32'h0, L);
    model_step(L, L, L, L, 32'h0, L);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic r, s, f, p, a;
      logic [31:0] t;
      model_compare(c);
      r = ($urandom_range(99) != 0);
      s = ($urandom_range(3) == 0);
      f = ($urandom_range(9) == 0);
      p = ($urandom_range(9) == 0);
      a = ($urandom_range(2) != 0);
      t = $urandom();
      drive(r, s, f, p, t, a);
      model_step(r, s, f, p, t, a);
      tick();
    end
    model_compare(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
